// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: parameter
// legality helpers, pointer-width helper and the sticky error-flag record.
package fifo_pkg;

    // Sticky error flags kept together so they reset and clear as one unit.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // True when v is a power of two and at least 2.
    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    // Full legality check of the FIFO parameter set.
    function automatic bit params_legal(input int data_width, input int depth,
                                        input int af_thresh, input int ae_thresh);
        return (data_width >= 1) && is_pow2(depth) &&
               (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: synchronous active-low reset, synchronous clear,
// and a single-step increment that rolls over modulo 2^WIDTH.
module fifo_ptr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] ptr_reg;
    logic [WIDTH-1:0] ptr_next;

    // Next pointer value: clear wins over increment; natural rollover at wrap.
    always_comb begin
        ptr_next = ptr_reg;
        if (clear) begin
            ptr_next = '0;
        end else if (inc) begin
            ptr_next = ptr_reg + WIDTH'(1);
        end
    end

    // Pointer register; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock show-ahead FIFO with occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and sticky
// overflow/underflow flags. All status outputs derive from registered
// pointers, so nothing combinationally depends on w_enable/r_enable.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        clear,
    input  logic                        w_enable,
    input  logic [DATA_WIDTH-1:0]       w_data,
    input  logic                        r_enable,
    output logic [DATA_WIDTH-1:0]       r_data,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [ptr_width(DEPTH)-1:0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LEVEL = PTR_W'(AE_THRESH);

    // Reject illegal parameter sets at elaboration time.
    generate
        if (!params_legal(DATA_WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_check
            $error("param_sync_fifo: illegal DATA_WIDTH/DEPTH/AF_THRESH/AE_THRESH");
        end
    endgenerate

    logic [PTR_W-1:0]      w_ptr;
    logic [PTR_W-1:0]      r_ptr;
    logic [ADDR_W-1:0]     w_addr;
    logic [ADDR_W-1:0]     r_addr;
    logic                  push_ok;
    logic                  pop_ok;
    logic [DEPTH-1:0]      wr_sel;
    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    fifo_err_t             err_reg;
    fifo_err_t             err_next;

    assign w_addr = w_ptr[ADDR_W-1:0];
    assign r_addr = r_ptr[ADDR_W-1:0];

    // Status from the pre-edge pointers.
    assign empty = (w_ptr == r_ptr);
    assign full  = (w_addr == r_addr) && (w_ptr[ADDR_W] != r_ptr[ADDR_W]);
    assign count = w_ptr - r_ptr;

    assign almost_full  = (count >= AF_LEVEL);
    assign almost_empty = (count <= AE_LEVEL);

    // A flush suppresses any push or pop requested in the same cycle.
    assign push_ok = w_enable && !full  && !clear;
    assign pop_ok  = r_enable && !empty && !clear;

    fifo_ptr #(
        .WIDTH (PTR_W)
    ) u_w_ptr (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .inc   (push_ok),
        .ptr   (w_ptr)
    );

    fifo_ptr #(
        .WIDTH (PTR_W)
    ) u_r_ptr (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .inc   (pop_ok),
        .ptr   (r_ptr)
    );

    // One-hot write select per storage entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push_ok && (w_addr == ADDR_W'(gi));
        end
    endgenerate

    // Storage: zeroed by reset, untouched by clear, written on accepted push.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!n_rst) begin
                mem_reg[i] <= '0;
            end else if (wr_sel[i]) begin
                mem_reg[i] <= w_data;
            end
        end
    end

    // Show-ahead read: head entry is always presented.
    assign r_data = mem_reg[r_addr];

    // Sticky error flags: set on a rejected request, dropped by clear.
    always_comb begin
        err_next = err_reg;
        if (clear) begin
            err_next = '0;
        end else begin
            if (w_enable && full) begin
                err_next.overflow = 1'b1;
            end
            if (r_enable && empty) begin
                err_next.underflow = 1'b1;
            end
        end
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            err_reg <= '0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign overflow  = err_reg.overflow;
    assign underflow = err_reg.underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_param_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 7;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          clear = 1'b0;
    logic          w_enable = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic          r_enable = 1'b0;
    logic [DW-1:0] r_data;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int n_cmp = 0;
    int n_bad = 0;
    int txn   = 0;

    // Reference model: the queue holds exactly the entries the FIFO should hold.
    logic [DW-1:0] model_q[$];
    bit            model_ov = 1'b0;
    bit            model_un = 1'b0;

    always #5 clk = ~clk;

    param_sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .w_enable     (w_enable),
        .w_data       (w_data),
        .r_enable     (r_enable),
        .r_data       (r_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s (txn %0d): got 0x%0h, expected 0x%0h", tag, txn, obs, exp);
        end
    endtask

    // Apply one clock of requests to the model, using the pre-edge occupancy.
    task automatic model_step(input bit rst_v, input bit clr, input bit we, input bit re,
                              input logic [DW-1:0] wd);
        int sz = model_q.size();
        if (!rst_v || clr) begin
            model_q.delete();
            model_ov = 1'b0;
            model_un = 1'b0;
        end else begin
            if (we && sz == DEPTH) model_ov = 1'b1;
            if (re && sz == 0)     model_un = 1'b1;
            if (re && sz > 0)      void'(model_q.pop_front());
            if (we && sz < DEPTH)  model_q.push_back(wd);
        end
    endtask

    task automatic check_outputs();
        int sz = model_q.size();
        check_value("count",        32'(count),        32'(sz));
        check_value("empty",        32'(empty),        32'(sz == 0));
        check_value("full",         32'(full),         32'(sz == DEPTH));
        check_value("almost_full",  32'(almost_full),  32'(sz >= AF));
        check_value("almost_empty", 32'(almost_empty), 32'(sz <= AE));
        check_value("overflow",     32'(overflow),     32'(model_ov));
        check_value("underflow",    32'(underflow),    32'(model_un));
        if (sz > 0) check_value("r_data", 32'(r_data), 32'(model_q[0]));
    endtask

    // One transaction: drive inputs, take the edge, sample #1 later and compare.
    task automatic cycle(input bit rst_v, input bit clr, input bit we, input bit re,
                         input logic [DW-1:0] wd);
        n_rst    = rst_v;
        clear    = clr;
        w_enable = we;
        r_enable = re;
        w_data   = wd;
        @(posedge clk);
        model_step(rst_v, clr, we, re, wd);
        #1;
        txn++;
        $display("txn %0d: n_rst=%0b clear=%0b we=%0b re=%0b wd=%02h -> count=%0d r_data=%02h ov=%0b un=%0b",
                 txn, rst_v, clr, we, re, wd, count, r_data, overflow, underflow);
        check_outputs();
    endtask

    task automatic push(input logic [DW-1:0] d);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic pop();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic do_clear();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        // Reset: storage zeroed, so the head reads 0.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_value("reset_r_data", 32'(r_data), 32'h0);

        // Single push then pop.
        push(8'hA5);
        check_value("first_push_r_data", 32'(r_data), 32'hA5);
        pop();

        // Fill to full, overflow attempt, drain in order.
        for (int i = 1; i <= DEPTH; i++) push(DW'(i));
        push(8'hFF);
        for (int i = 0; i < DEPTH; i++) pop();

        // Full with simultaneous push+pop: only the pop happens.
        do_clear();
        for (int i = 1; i <= DEPTH; i++) push(DW'(i + 16));
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h55);
        for (int i = 0; i < DEPTH; i++) pop();

        // Empty with simultaneous push+pop: only the push happens.
        do_clear();
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h3C);
        check_value("empty_both_r_data", 32'(r_data), 32'h3C);

        // Wrap-around at constant occupancy.
        do_clear();
        for (int i = 0; i < 4; i++) push(DW'($urandom));
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, DW'($urandom));
        for (int i = 0; i < 4; i++) pop();

        // Clear at count=5 with a push pending; next push lands at the head.
        for (int i = 0; i < 5; i++) push(DW'(i + 8'h40));
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'hEE);
        push(8'h77);
        check_value("after_clear_r_data", 32'(r_data), 32'h77);
        pop();

        // Reset at count=5 with a push pending; storage is wiped.
        for (int i = 0; i < 5; i++) push(DW'(i + 8'h60));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'hDD);
        check_value("after_reset_r_data", 32'(r_data), 32'h0);
        push(8'h9E);
        check_value("after_reset_push", 32'(r_data), 32'h9E);

        // Randomized traffic in phases of different push/pop bias.
        for (int ph = 0; ph < 4; ph++) begin
            int wp = (ph == 0) ? 80 : (ph == 1) ? 30 : 55;
            int rp = (ph == 0) ? 30 : (ph == 1) ? 80 : 50;
            for (int i = 0; i < 100; i++) begin
                bit rst_v = ($urandom_range(0, 199) != 0);
                bit clr   = ($urandom_range(0, 59) == 0);
                bit we    = ($urandom_range(0, 99) < wp);
                bit re    = ($urandom_range(0, 99) < rp);
                cycle(rst_v, clr, we, re, DW'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
